// File: rtl/weight_seq_ctrl_nn_if.sv
// Weight-load and accumulator-readout channels between the sequencer and the MAC array.
// Pure wiring, no latency.
// Both channels are valid/ready; master (sequencer) owns w_ready and rd_valid.
interface weight_seq_ctrl_nn_if #(
  parameter int N_MACS = 4,
  parameter int ROW_W  = 8,
  parameter int IDX_W  = 2
);
  logic              w_valid;
  logic              w_ready;
  logic [N_MACS-1:0] weight_ctrl;
  logic [ROW_W-1:0]  row_idx;
  logic              rd_valid;
  logic              rd_ready;
  logic [IDX_W-1:0]  rd_idx;

  // Sequencer side.
  modport master (
    input  w_valid, rd_ready,
    output w_ready, weight_ctrl, row_idx, rd_valid, rd_idx
  );

  // Weight source / MAC array side.
  modport slave (
    output w_valid, rd_ready,
    input  w_ready, weight_ctrl, row_idx, rd_valid, rd_idx
  );
endinterface

// File: rtl/weight_seq_ctrl_nn.sv
// Sequences a counted weight-load phase and a counted accumulator-readout phase for an N-MAC array.
// Start -> phase entry one cycle later; strobes are same-cycle with the handshake; status pulses are registered.
// w_valid low stalls LOAD and rd_ready low stalls LAYER indefinitely; mode==0 aborts either phase.
module weight_seq_ctrl_nn #(
  parameter int N_MACS = 4,
  parameter int GROUP  = 2,
  parameter int ROW_W  = 8,
  parameter int IDX_W  = 2,
  localparam int N_GROUPS = N_MACS / GROUP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          mode,
  input  logic [ROW_W-1:0]    num_rows,
  input  logic [N_GROUPS-1:0] group_mask,
  weight_seq_ctrl_nn_if.master bus,
  output logic [2:0]          load,
  output logic                busy,
  output logic                load_ready,
  output logic                layer_ready,
  output logic                load_done,
  output logic                layer_done,
  output logic                abort,
  output logic                err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_LAYER = 2'd2;

  localparam logic [2:0] MODE_IDLE  = 3'd0;
  localparam logic [2:0] MODE_LOAD  = 3'd1;
  localparam logic [2:0] MODE_LAYER = 3'd2;

  localparam logic [IDX_W-1:0] RD_LAST = IDX_W'(N_MACS - 1);

  logic [1:0]          state;
  logic [ROW_W-1:0]    row_cnt;
  logic [IDX_W-1:0]    rd_cnt;
  logic [ROW_W-1:0]    nrows_q;
  logic [N_GROUPS-1:0] mask_q;

  logic w_hs;
  logic rd_hs;
  logic row_last;
  logic rd_last;

  // State-decoded handshake outputs; all zero in IDLE, so an async reset clears them at once.
  assign bus.w_ready  = (state == ST_LOAD);
  assign bus.rd_valid = (state == ST_LAYER);
  assign bus.row_idx  = row_cnt;
  assign bus.rd_idx   = rd_cnt;

  assign busy        = (state != ST_IDLE);
  assign load_ready  = (state == ST_LOAD);
  assign layer_ready = (state == ST_LAYER);

  assign w_hs     = bus.w_valid & bus.w_ready;
  assign rd_hs    = bus.rd_valid & bus.rd_ready;
  assign row_last = (row_cnt == nrows_q - ROW_W'(1));
  assign rd_last  = (rd_cnt == RD_LAST);

  // Each MAC captures on the handshake only if its group is enabled; still fires on an aborted final row.
  for (genvar i = 0; i < N_MACS; i++) begin : g_wctrl
    assign bus.weight_ctrl[i] = w_hs & mask_q[i / GROUP];
  end

  // Phase FSM, row/readout counters and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      row_cnt    <= '0;
      rd_cnt     <= '0;
      nrows_q    <= '0;
      mask_q     <= '0;
      load       <= 3'b000;
      load_done  <= 1'b0;
      layer_done <= 1'b0;
      abort      <= 1'b0;
      err        <= 1'b0;
    end else begin
      load       <= 3'b000;
      load_done  <= 1'b0;
      layer_done <= 1'b0;
      abort      <= 1'b0;
      err        <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            case (mode)
              MODE_LOAD: begin
                // An empty mask can capture nothing, so it is a bad request even with rows pending.
                if (group_mask == '0) begin
                  err <= 1'b1;
                end else if (num_rows == '0) begin
                  load_done <= 1'b1;
                end else begin
                  nrows_q <= num_rows;
                  mask_q  <= group_mask;
                  row_cnt <= '0;
                  load    <= 3'b001;
                  state   <= ST_LOAD;
                end
              end
              MODE_LAYER: begin
                rd_cnt <= '0;
                load   <= 3'b010;
                state  <= ST_LAYER;
              end
              default: err <= 1'b1;
            endcase
          end
        end

        ST_LOAD: begin
          if (mode == MODE_IDLE) begin
            abort   <= 1'b1;
            row_cnt <= '0;
            state   <= ST_IDLE;
          end else if (w_hs) begin
            if (row_last) begin
              load_done <= 1'b1;
              row_cnt   <= '0;
              state     <= ST_IDLE;
            end else begin
              row_cnt <= row_cnt + ROW_W'(1);
            end
          end
        end

        ST_LAYER: begin
          if (mode == MODE_IDLE) begin
            abort  <= 1'b1;
            rd_cnt <= '0;
            state  <= ST_IDLE;
          end else if (rd_hs) begin
            if (rd_last) begin
              layer_done <= 1'b1;
              rd_cnt     <= '0;
              state      <= ST_IDLE;
            end else begin
              rd_cnt <= rd_cnt + IDX_W'(1);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_seq_ctrl_nn.sv
// Directed bench for weight_seq_ctrl_nn: per-cycle expected output snapshots are queued as each
// step is driven and compared at the following falling edge.
module tb_weight_seq_ctrl_nn;

  localparam int N_MACS   = 4;
  localparam int GROUP    = 2;
  localparam int ROW_W    = 8;
  localparam int IDX_W    = 2;
  localparam int N_GROUPS = N_MACS / GROUP;

  localparam int P_NONE = 0;
  localparam int P_LD   = 1;
  localparam int P_YD   = 2;
  localparam int P_AB   = 3;
  localparam int P_ER   = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [2:0]          mode;
  logic [ROW_W-1:0]    num_rows;
  logic [N_GROUPS-1:0] group_mask;
  logic [2:0]          load;
  logic                busy, load_ready, layer_ready;
  logic                load_done, layer_done, abort, err;

  weight_seq_ctrl_nn_if #(.N_MACS(N_MACS), .ROW_W(ROW_W), .IDX_W(IDX_W)) bus ();

  weight_seq_ctrl_nn #(
    .N_MACS(N_MACS), .GROUP(GROUP), .ROW_W(ROW_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_rows(num_rows),
    .group_mask(group_mask), .bus(bus), .load(load), .busy(busy),
    .load_ready(load_ready), .layer_ready(layer_ready), .load_done(load_done),
    .layer_done(layer_done), .abort(abort), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             w_ready;
    logic [3:0]       weight_ctrl;
    logic [ROW_W-1:0] row_idx;
    logic             rd_valid;
    logic [IDX_W-1:0] rd_idx;
    logic [2:0]       load;
    logic             busy;
    logic             load_ready;
    logic             layer_ready;
    logic             load_done;
    logic             layer_done;
    logic             abort;
    logic             err;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // st: 0 IDLE, 1 LOAD, 2 LAYER; pl selects which single status pulse is expected.
  function automatic obs_t mk(int st, int wc, int ri, int rx, int ld, int pl);
    obs_t e;
    e             = '0;
    e.w_ready     = (st == 1);
    e.rd_valid    = (st == 2);
    e.busy        = (st != 0);
    e.load_ready  = (st == 1);
    e.layer_ready = (st == 2);
    e.weight_ctrl = 4'(wc);
    e.row_idx     = ROW_W'(ri);
    e.rd_idx      = IDX_W'(rx);
    e.load        = 3'(ld);
    e.load_done   = (pl == P_LD);
    e.layer_done  = (pl == P_YD);
    e.abort       = (pl == P_AB);
    e.err         = (pl == P_ER);
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.w_ready     = bus.w_ready;
    o.weight_ctrl = bus.weight_ctrl;
    o.row_idx     = bus.row_idx;
    o.rd_valid    = bus.rd_valid;
    o.rd_idx      = bus.rd_idx;
    o.load        = load;
    o.busy        = busy;
    o.load_ready  = load_ready;
    o.layer_ready = layer_ready;
    o.load_done   = load_done;
    o.layer_done  = layer_done;
    o.abort       = abort;
    o.err         = err;
    return o;
  endfunction

  task automatic compare(input string tag);
    obs_t e;
    obs_t o;
    e = exp_q.pop_front();
    o = sample();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Inputs are already driven (posedge+1); check at the falling edge, then move to the next posedge+1.
  task automatic tick(input string tag, input obs_t e);
    exp_q.push_back(e);
    @(negedge clk);
    compare(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    mode         = 3'd0;
    num_rows     = 8'd0;
    group_mask   = 2'b00;
    bus.w_valid  = 1'b0;
    bus.rd_ready = 1'b0;

    #12;
    exp_q.push_back(mk(0, 0, 0, 0, 0, P_NONE));
    compare("reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full mask, three rows, w_valid held high.
    start = 1'b1; mode = 3'd1; num_rows = 8'd3; group_mask = 2'b11; bus.w_valid = 1'b1;
    tick("t1_start", mk(0, 0, 0, 0, 0, P_NONE));
    start = 1'b0;
    tick("t1_row0", mk(1, 4'hF, 0, 0, 3'b001, P_NONE));
    tick("t1_row1", mk(1, 4'hF, 1, 0, 0, P_NONE));
    tick("t1_row2", mk(1, 4'hF, 2, 0, 0, P_NONE));
    tick("t1_done", mk(0, 0, 0, 0, 0, P_LD));

    // Upper group only, two rows, gap in w_valid; num_rows changes after start must not matter.
    start = 1'b1; mode = 3'd1; num_rows = 8'd2; group_mask = 2'b10; bus.w_valid = 1'b0;
    tick("t2_start", mk(0, 0, 0, 0, 0, P_NONE));
    start = 1'b0; num_rows = 8'd7; bus.w_valid = 1'b1;
    tick("t2_hs0", mk(1, 4'hC, 0, 0, 3'b001, P_NONE));
    bus.w_valid = 1'b0;
    tick("t2_gap", mk(1, 0, 1, 0, 0, P_NONE));
    bus.w_valid = 1'b1;
    tick("t2_hs1", mk(1, 4'hC, 1, 0, 0, P_NONE));
    bus.w_valid = 1'b0;
    tick("t2_done", mk(0, 0, 0, 0, 0, P_LD));

    // Readout with rd_ready 1,1,0,1,1; stray start mid-phase is ignored; w_valid high has no effect.
    start = 1'b1; mode = 3'd2; bus.rd_ready = 1'b0; bus.w_valid = 1'b1;
    tick("t3_start", mk(0, 0, 0, 0, 0, P_NONE));
    start = 1'b0; bus.rd_ready = 1'b1;
    tick("t3_rd0", mk(2, 0, 0, 0, 3'b010, P_NONE));
    tick("t3_rd1", mk(2, 0, 0, 1, 0, P_NONE));
    bus.rd_ready = 1'b0; start = 1'b1; mode = 3'd1; num_rows = 8'd0; group_mask = 2'b00;
    tick("t3_stall", mk(2, 0, 0, 2, 0, P_NONE));
    start = 1'b0; mode = 3'd2; bus.rd_ready = 1'b1;
    tick("t3_rd2", mk(2, 0, 0, 2, 0, P_NONE));
    tick("t3_rd3", mk(2, 0, 0, 3, 0, P_NONE));
    bus.rd_ready = 1'b0;
    tick("t3_done", mk(0, 0, 0, 0, 0, P_YD));
    tick("t3_quiet", mk(0, 0, 0, 0, 0, P_NONE));

    // Abort after one of four rows, then restart; abort beats a same-cycle final handshake.
    start = 1'b1; mode = 3'd1; num_rows = 8'd4; group_mask = 2'b01; bus.w_valid = 1'b1;
    tick("t4_start", mk(0, 0, 0, 0, 0, P_NONE));
    start = 1'b0;
    tick("t4_row0", mk(1, 4'h3, 0, 0, 3'b001, P_NONE));
    bus.w_valid = 1'b0; mode = 3'd0;
    tick("t4_abort_req", mk(1, 0, 1, 0, 0, P_NONE));
    start = 1'b1; mode = 3'd1; num_rows = 8'd1; group_mask = 2'b11; bus.w_valid = 1'b1;
    tick("t4_abort", mk(0, 0, 0, 0, 0, P_AB));
    start = 1'b0; mode = 3'd0;
    tick("t4_abort_last", mk(1, 4'hF, 0, 0, 3'b001, P_NONE));
    mode = 3'd1; bus.w_valid = 1'b0;
    tick("t4_abort2", mk(0, 0, 0, 0, 0, P_AB));
    start = 1'b1; bus.w_valid = 1'b1;
    tick("t4_restart", mk(0, 0, 0, 0, 0, P_NONE));
    start = 1'b0;
    tick("t4_row_only", mk(1, 4'hF, 0, 0, 3'b001, P_NONE));
    bus.w_valid = 1'b0;
    tick("t4_done", mk(0, 0, 0, 0, 0, P_LD));

    // Rejected starts and the zero-row load.
    start = 1'b1; mode = 3'd3; num_rows = 8'd2; group_mask = 2'b11;
    tick("t5_mode3", mk(0, 0, 0, 0, 0, P_NONE));
    mode = 3'd1; group_mask = 2'b00;
    tick("t5_err_mode3", mk(0, 0, 0, 0, 0, P_ER));
    group_mask = 2'b11; num_rows = 8'd0;
    tick("t5_err_mask0", mk(0, 0, 0, 0, 0, P_ER));
    mode = 3'd0;
    tick("t5_zero_rows", mk(0, 0, 0, 0, 0, P_LD));
    mode = 3'd7;
    tick("t5_err_mode0", mk(0, 0, 0, 0, 0, P_ER));
    start = 1'b0; mode = 3'd1;
    tick("t5_err_mode7", mk(0, 0, 0, 0, 0, P_ER));
    tick("t5_quiet", mk(0, 0, 0, 0, 0, P_NONE));

    // Asynchronous reset in the middle of a load.
    start = 1'b1; mode = 3'd1; num_rows = 8'd5; group_mask = 2'b11; bus.w_valid = 1'b1;
    tick("t6_start", mk(0, 0, 0, 0, 0, P_NONE));
    start = 1'b0;
    tick("t6_row0", mk(1, 4'hF, 0, 0, 3'b001, P_NONE));
    tick("t6_row1", mk(1, 4'hF, 1, 0, 0, P_NONE));
    #2;
    exp_q.push_back(mk(1, 4'hF, 2, 0, 0, P_NONE));
    compare("t6_row2");
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, P_NONE));
    compare("t6_async_rst");
    @(posedge clk);
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, P_NONE));
    compare("t6_rst_hold");
    rst_n = 1'b1;
    tick("t6_rel0", mk(0, 0, 0, 0, 0, P_NONE));
    tick("t6_rel1", mk(0, 0, 0, 0, 0, P_NONE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
